issue_decode_stage: RTL
=======================

Name: issue_decode_stage

Overview:
- ISSUE_W-lane pipelined control decoder for the superscalar front end. Sits between the fetch bundle buffer and the register-read/issue stage.
- Accepts a fetch bundle of ISSUE_W instructions and decodes each lane into the standard control word.
- Splits the bundle into in-order issue groups when a lane has a RAW dependency on an earlier lane, exceeds the memory-port budget, or follows a branch.
- Emits one issue group per output handshake through a registered output.

Parameters:
ISSUE_W, 2, lanes per bundle (1..4)
MEM_PORTS, 1, max lw/sw per issued group (1..ISSUE_W)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  bundle offered
in_ready  out  1  bundle accepted when in_valid&&in_ready at posedge
in_instr  in  32*ISSUE_W  lane i = bits [32i+31:32i]
out_valid  out  1  issue group valid
out_ready  in  1  downstream accepts group
out_lane_valid  out  ISSUE_W  lanes present in this group
out_ctrl  out  12*ISSUE_W  per lane {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,Branch,BranchN,SignExt,ALUControl[3:0]}
out_instr  out  32*ISSUE_W  raw instructions, aligned with out_ctrl
out_illegal  out  ISSUE_W  lane opcode/funct not decodable
out_jump  out  ISSUE_W  lane is j (see optional feature)

Behaviour:
- Decode per lane, combinational, from the bundle register:
  - R-type 0x00: ctrl 1000_1000 + ALUControl by funct: add 0000, addu 0001, sub 0010, subu 0011, and 0100, or 0101, xor 0110, nor 0111, slt 1100, sltu 1101.
  - lw 0x23: 1101_0001_0000.
  - sw 0x2B: 0011_0001_0000.
  - beq 0x04: 0000_0101_0011.
  - bne 0x05: 0000_0011_0011.
  - addi 0x08: 1001_0001_0000.
  - addiu 0x09: 1001_0000_0001.
  - andi 0x0C: 1001_0000_0100.
  - ori 0x0D: 1001_0000_0101.
  - xori 0x0E: 1001_0000_0110.
  - Any other opcode, or an unlisted R funct: ctrl all-zero, illegal=1.
- Destination register: rd if RegDst=1, else rt. A lane writes only if RegWrite=1 and dest!=0.
- Sources: rs for all opcodes; rt additionally for R-type, sw, beq, bne.
- State:
  - Bundle register B and pending mask P[ISSUE_W-1:0].
  - P==0 means idle. A handshake loads B<=in_instr and P<=all ones.
- Group formation, combinational from B and P:
  - Start at the lowest set bit of P.
  - Extend to the next higher lane while all of the following hold: that lane is pending; it has no RAW on any earlier lane already in the group; the group's lw+sw count stays <=MEM_PORTS; no earlier lane in the group is a branch, jump or illegal.
  - An illegal or jump lane may join a group but terminates it.
  - The group is always non-empty when P!=0.
- Advance: adv = !out_valid || out_ready.
  - When adv && P!=0: output register <= group (lanes outside the group get zero ctrl/illegal/instr), out_valid<=1, and P clears the group bits.
  - When adv && P==0: out_valid<=0.
  - While out_valid && !out_ready: all outputs are held stable.
- in_ready = (P==0) || (adv && group==P). A new bundle may load in the same cycle the last group of the previous bundle issues.
- Latency: bundle accepted at edge E0; its first group is visible on outputs after edge E1. Sustained throughput is one group per cycle.
- Reset, at any time including mid-bundle: P<=0, out_valid<=0; out_lane_valid, out_ctrl, out_instr, out_illegal and out_jump all <=0; B is don't-care. in_ready is 1 in the cycle after reset deasserts.

Optional Feature:
- Macro ISSUE_DECODE_JUMP_EN.
- Defined: opcode 0x02 (j) decodes to ctrl all-zero, illegal=0, out_jump=1, and terminates its group.
- Undefined: 0x02 is illegal, and out_jump is constant 0.

Test Plan:
- ISSUE_W=2, bundle {lane0 0x00221820 add $3,$1,$2; lane1 0x00222824 and $5,$1,$2} -> one group: out_lane_valid=2'b11, ctrl lane0 0x880, lane1 0x884; in_ready stays 1.
- Bundle {0x00221820; 0x00612022 sub $4,$3,$1} -> two groups on consecutive cycles: 2'b01 (ctrl 0x880), then 2'b10 (ctrl 0x882); in_ready=0 during the first group.
- Bundle {0x00220020 add $0,$1,$2; 0x00012022 sub $4,$0,$1} -> no dependency through $0: single group 2'b11.
- MEM_PORTS=1, bundle {0x8D280000 lw; 0xAD6A0004 sw} -> groups 2'b01 (ctrl 0xD10) then 2'b10 (ctrl 0x310). Repeat with MEM_PORTS=2 -> single group.
- Hold out_ready=0 for 3 cycles with a group pending -> outputs stable; accept on out_ready=1. Assert reset mid-split -> out_valid=0 next cycle and the remaining lane is discarded.
- Lane0 0x08000010 (j) -> with ISSUE_DECODE_JUMP_EN: out_jump=2'b01 and lane1 is issued next cycle. Without the macro: out_illegal=2'b01, ctrl 0x000, and lane1 still issues next cycle.

Source files
------------

// File: rtl/issue_decode_if.sv
// Handshake and data bundle between the fetch buffer, the issue decode stage
// and the register-read/issue stage.
//   in_valid/in_ready/in_instr : fetch bundle offered to the decoder
//   out_valid/out_ready        : issue group handshake
//   out_lane_valid             : lanes present in the current group
//   out_ctrl                   : 12-bit control word per lane
//   out_instr                  : raw instruction per lane
//   out_illegal/out_jump       : per-lane decode flags
// master = producer/consumer side (fetch + issue), slave = decode stage.
interface issue_decode_if #(
    parameter int ISSUE_W = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [32*ISSUE_W-1:0]   in_instr;
    logic                    out_valid;
    logic                    out_ready;
    logic [ISSUE_W-1:0]      out_lane_valid;
    logic [12*ISSUE_W-1:0]   out_ctrl;
    logic [32*ISSUE_W-1:0]   out_instr;
    logic [ISSUE_W-1:0]      out_illegal;
    logic [ISSUE_W-1:0]      out_jump;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_ctrl, out_instr,
               out_illegal, out_jump
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_lane_valid, out_ctrl, out_instr,
               out_illegal, out_jump
    );
endinterface

// File: rtl/issue_decode_stage.sv
// ISSUE_W-lane control decoder. Latches a fetch bundle, decodes every lane
// into {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,Branch,BranchN,SignExt,
// ALUControl[3:0]} and issues the bundle as in-order groups, splitting on
// intra-group RAW hazards, memory-port budget and after branch/jump/illegal.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : issue_decode_if.slave (input bundle handshake, registered
//           issue group output)
// Optional feature: define ISSUE_DECODE_JUMP_EN to decode opcode 0x02 (j);
// otherwise j is illegal and out_jump is tied to zero.
module issue_decode_stage #(
    parameter int ISSUE_W   = 2,
    parameter int MEM_PORTS = 1
) (
    input  logic           clk,
    input  logic           reset,
    issue_decode_if.slave  bus
);
    localparam logic [2:0] MEM_LIM = 3'(MEM_PORTS);

    typedef struct packed {
        logic [11:0] ctrl;
        logic        illegal;
        logic        jump;
        logic        term;    // ends the group it joins
        logic        mem;
        logic        wr;      // RegWrite with a non-zero destination
        logic        use_rt;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } dec_t;

    logic [32*ISSUE_W-1:0] b_q;
    logic [ISSUE_W-1:0]    pend_q;
    logic                  vld_q;
    logic [ISSUE_W-1:0]    lane_q, lane_d;
    logic [12*ISSUE_W-1:0] ctrl_q, ctrl_d;
    logic [32*ISSUE_W-1:0] instr_q, instr_d;
    logic [ISSUE_W-1:0]    ill_q, ill_d;

    dec_t                  dec [ISSUE_W];
    logic                  adv;
    logic                  in_rdy;

    // Per-lane decode from the bundle register
    always_comb begin
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            dec[i]    = '0;
            dec[i].rs = b_q[32*i+21 +: 5];
            dec[i].rt = b_q[32*i+16 +: 5];
            case (b_q[32*i+26 +: 6])
                6'h00: begin
                    dec[i].use_rt = 1'b1;
                    dec[i].ctrl   = 12'h880;
                    case (b_q[32*i +: 6])
                        6'h20: dec[i].ctrl[3:0] = 4'b0000;
                        6'h21: dec[i].ctrl[3:0] = 4'b0001;
                        6'h22: dec[i].ctrl[3:0] = 4'b0010;
                        6'h23: dec[i].ctrl[3:0] = 4'b0011;
                        6'h24: dec[i].ctrl[3:0] = 4'b0100;
                        6'h25: dec[i].ctrl[3:0] = 4'b0101;
                        6'h26: dec[i].ctrl[3:0] = 4'b0110;
                        6'h27: dec[i].ctrl[3:0] = 4'b0111;
                        6'h2A: dec[i].ctrl[3:0] = 4'b1100;
                        6'h2B: dec[i].ctrl[3:0] = 4'b1101;
                        default: begin
                            dec[i].ctrl    = '0;
                            dec[i].illegal = 1'b1;
                        end
                    endcase
                end
                6'h23: begin dec[i].ctrl = 12'hD10; dec[i].mem = 1'b1; end
                6'h2B: begin
                    dec[i].ctrl   = 12'h310;
                    dec[i].mem    = 1'b1;
                    dec[i].use_rt = 1'b1;
                end
                6'h04: begin dec[i].ctrl = 12'h053; dec[i].term = 1'b1; dec[i].use_rt = 1'b1; end
                6'h05: begin dec[i].ctrl = 12'h033; dec[i].term = 1'b1; dec[i].use_rt = 1'b1; end
                6'h08: dec[i].ctrl = 12'h910;
                6'h09: dec[i].ctrl = 12'h901;
                6'h0C: dec[i].ctrl = 12'h904;
                6'h0D: dec[i].ctrl = 12'h905;
                6'h0E: dec[i].ctrl = 12'h906;
`ifdef ISSUE_DECODE_JUMP_EN
                6'h02: dec[i].jump = 1'b1;
`endif
                default: dec[i].illegal = 1'b1;
            endcase
            if (dec[i].illegal || dec[i].jump)
                dec[i].term = 1'b1;
            dec[i].dest = dec[i].ctrl[7] ? b_q[32*i+11 +: 5] : b_q[32*i+16 +: 5];
            dec[i].wr   = dec[i].ctrl[11] && (dec[i].dest != 5'd0);
        end
    end

    // Group formation: grow upward from the lowest pending lane until a
    // hazard, the memory budget or a terminating lane stops it.
    logic [ISSUE_W-1:0] grp;
    always_comb begin
        logic       started;
        logic       stop;
        logic       raw;
        logic [2:0] memcnt;
        grp     = '0;
        started = 1'b0;
        stop    = 1'b0;
        memcnt  = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            raw = 1'b0;
            for (int unsigned j = 0; j < i; j++) begin
                if (grp[j] && dec[j].wr &&
                    ((dec[j].dest == dec[i].rs) ||
                     (dec[i].use_rt && (dec[j].dest == dec[i].rt))))
                    raw = 1'b1;
            end
            if (!stop) begin
                if (pend_q[i]) begin
                    if (!started || (!raw && ((memcnt + 3'(dec[i].mem)) <= MEM_LIM))) begin
                        grp[i]  = 1'b1;
                        started = 1'b1;
                        memcnt  = memcnt + 3'(dec[i].mem);
                        stop    = dec[i].term;
                    end else begin
                        stop = 1'b1;
                    end
                end else if (started) begin
                    stop = 1'b1;
                end
            end
        end
    end

    // Lanes outside the group are zeroed in the output register
    always_comb begin
        lane_d  = grp;
        ctrl_d  = '0;
        instr_d = '0;
        ill_d   = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            if (grp[i]) begin
                ctrl_d[12*i +: 12]  = dec[i].ctrl;
                instr_d[32*i +: 32] = b_q[32*i +: 32];
                ill_d[i]            = dec[i].illegal;
            end
        end
    end

    assign adv    = !vld_q || bus.out_ready;
    assign in_rdy = (pend_q == '0) || (adv && (grp == pend_q));

    always_ff @(posedge clk) begin
        if (bus.in_valid && in_rdy)
            b_q <= bus.in_instr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            vld_q   <= 1'b0;
            lane_q  <= '0;
            ctrl_q  <= '0;
            instr_q <= '0;
            ill_q   <= '0;
        end else begin
            if (adv) begin
                if (pend_q != '0) begin
                    vld_q   <= 1'b1;
                    lane_q  <= lane_d;
                    ctrl_q  <= ctrl_d;
                    instr_q <= instr_d;
                    ill_q   <= ill_d;
                end else begin
                    vld_q <= 1'b0;
                end
            end
            // A new bundle may overwrite the mask as its predecessor's last group issues
            if (bus.in_valid && in_rdy)
                pend_q <= '1;
            else if (adv && (pend_q != '0))
                pend_q <= pend_q & ~grp;
        end
    end

`ifdef ISSUE_DECODE_JUMP_EN
    logic [ISSUE_W-1:0] jmp_q, jmp_d;
    always_comb begin
        jmp_d = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++)
            jmp_d[i] = grp[i] && dec[i].jump;
    end
    always_ff @(posedge clk) begin
        if (reset)
            jmp_q <= '0;
        else if (adv && (pend_q != '0))
            jmp_q <= jmp_d;
    end
    assign bus.out_jump = jmp_q;
`else
    assign bus.out_jump = '0;
`endif

    assign bus.in_ready       = in_rdy;
    assign bus.out_valid      = vld_q;
    assign bus.out_lane_valid = lane_q;
    assign bus.out_ctrl       = ctrl_q;
    assign bus.out_instr      = instr_q;
    assign bus.out_illegal    = ill_q;
endmodule
